decode_stage_hz: RTL and testbench

//  Parametrised ID stage plus ID/EX pipeline register for the 5-stage RV32I core. Contains the decoder, register file with WB->ID bypass, immediate generator and load-use hazard detection.

---
 rtl/decode_stage_hz.sv | 174 +++++++++++++++++
 tb/tb_decode_stage_hz.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_hz.sv
// rtl/decode_stage_hz.sv - RV32I decode stage with register file, WB bypass, load-use stall and ID/EX register
module decode_stage_hz #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int REG_AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       InstrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic              ValidD,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RDW,
  input  logic [XLEN-1:0]   ResultW,
  input  logic              FlushE,
  input  logic              HoldE,
  output logic              StallD,
  output logic              ValidE,
  output logic              RegWriteE,
  output logic              ALUSrcE,
  output logic              MemWriteE,
  output logic [1:0]        ResultSrcE,
  output logic              BranchE,
  output logic              JumpE,
  output logic [2:0]        ALUControlE,
  output logic [XLEN-1:0]   RD1_E,
  output logic [XLEN-1:0]   RD2_E,
  output logic [XLEN-1:0]   Imm_Ext_E,
  output logic [REG_AW-1:0] RD_E,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              alu_src;
    logic              mem_write;
    logic [1:0]        result_src;
    logic              branch;
    logic              jump;
    logic [2:0]        alu_ctrl;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
  } ex_t;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [REG_AW-1:0] rs1_d, rs2_d, rd_d;
  logic [XLEN-1:0]   rf [NREG];
  logic [XLEN-1:0]   rd1_d, rd2_d;
  logic [XLEN-1:0]   imm_i, imm_s, imm_b, imm_j;
  logic [2:0]        alu_f3;
  logic              lu;
  ex_t               dec, ex_q;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign rs1_d  = InstrD[15 +: REG_AW];
  assign rs2_d  = InstrD[20 +: REG_AW];
  assign rd_d   = InstrD[7 +: REG_AW];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (RegWriteW && RDW != '0) begin
      rf[RDW] <= ResultW;
    end
  end

  // WB result is forwarded into the same-cycle read so ID never sees a stale value
  assign rd1_d = (rs1_d == '0) ? '0 : (RegWriteW && RDW == rs1_d) ? ResultW : rf[rs1_d];
  assign rd2_d = (rs2_d == '0) ? '0 : (RegWriteW && RDW == rs2_d) ? ResultW : rf[rs2_d];

  assign imm_i = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
  assign imm_s = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
  assign imm_b = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};

  always_comb begin
    alu_f3 = 3'b000;
    case (funct3)
      3'b010:  alu_f3 = 3'b101;
      3'b110:  alu_f3 = 3'b011;
      3'b111:  alu_f3 = 3'b010;
      default: alu_f3 = 3'b000;
    endcase
  end

  always_comb begin
    dec          = '0;
    dec.rd1      = rd1_d;
    dec.rd2      = rd2_d;
    dec.rd       = rd_d;
    dec.rs1      = rs1_d;
    dec.rs2      = rs2_d;
    dec.pc       = PCD;
    dec.pc_plus4 = PCPlus4D;
    case (opcode)
      OP_LW:  begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.result_src = 2'b01; dec.imm = imm_i; end
      OP_SW:  begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; dec.imm = imm_s; end
      OP_R:   begin
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = (funct3 == 3'b000 && InstrD[30]) ? 3'b001 : alu_f3;
      end
      OP_I:   begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_ctrl = alu_f3; dec.imm = imm_i; end
      OP_BEQ: begin dec.branch = 1'b1; dec.alu_ctrl = 3'b001; dec.imm = imm_b; end
      OP_JAL: begin dec.jump = 1'b1; dec.reg_write = 1'b1; dec.result_src = 2'b10; dec.imm = imm_j; end
      default: ;
    endcase
    // An invalid slot carries its data fields but never any side-effecting control
    dec.valid = ValidD;
    if (!ValidD) begin
      dec.reg_write  = 1'b0;
      dec.alu_src    = 1'b0;
      dec.mem_write  = 1'b0;
      dec.result_src = 2'b00;
      dec.branch     = 1'b0;
      dec.jump       = 1'b0;
      dec.alu_ctrl   = 3'b000;
    end
  end

  // Raw rs fields are compared even for formats that do not read them
  assign lu = ValidD && ex_q.valid && ex_q.reg_write && ex_q.result_src == 2'b01 &&
              ex_q.rd != '0 && (ex_q.rd == rs1_d || ex_q.rd == rs2_d);
  assign StallD = lu || HoldE;

  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      ex_q <= '0;
    end else if (HoldE) begin
      ex_q <= ex_q;
    end else if (lu) begin
      ex_q <= '0;
    end else begin
      ex_q <= dec;
    end
  end

  assign ValidE      = ex_q.valid;
  assign RegWriteE   = ex_q.reg_write;
  assign ALUSrcE     = ex_q.alu_src;
  assign MemWriteE   = ex_q.mem_write;
  assign ResultSrcE  = ex_q.result_src;
  assign BranchE     = ex_q.branch;
  assign JumpE       = ex_q.jump;
  assign ALUControlE = ex_q.alu_ctrl;
  assign RD1_E       = ex_q.rd1;
  assign RD2_E       = ex_q.rd2;
  assign Imm_Ext_E   = ex_q.imm;
  assign RD_E        = ex_q.rd;
  assign Rs1E        = ex_q.rs1;
  assign Rs2E        = ex_q.rs2;
  assign PCE         = ex_q.pc;
  assign PCPlus4E    = ex_q.pc_plus4;

endmodule

// File: tb/tb_decode_stage_hz.sv
// tb/tb_decode_stage_hz.sv - scoreboard bench for decode_stage_hz against a reference model
module tb_decode_stage_hz;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] InstrD = '0, PCD = '0, PCPlus4D = '0, ResultW = '0;
  logic        ValidD = 1'b0, RegWriteW = 1'b0, FlushE = 1'b0, HoldE = 1'b0;
  logic [4:0]  RDW = '0;
  logic        StallD, ValidE, RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0]  RD_E, Rs1E, Rs2E;

  decode_stage_hz dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE), .HoldE(HoldE),
    .StallD(StallD), .ValidE(ValidE), .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE),
    .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .BranchE(BranchE), .JumpE(JumpE),
    .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
    .RD_E(RD_E), .Rs1E(Rs1E), .Rs2E(Rs2E), .PCE(PCE), .PCPlus4E(PCPlus4E)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid, rw, alusrc, mw, br, jp;
    int unsigned rsrc, alu, rd, rs1, rs2;
    bit [31:0]   a, b, imm, pc, pc4;
    bit          ctl_ok, imm_ok;
  } ex_t;

  ex_t         exp_q[$];
  bit          stall_q[$];
  ex_t         m_ex;
  bit [31:0]   m_regs [32];
  bit          known = 0;
  bit          last_stall = 0;
  int          n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] sext(input int unsigned v, input int bits);
    return (v >= (1 << (bits - 1))) ? 32'(v) - 32'(1 << bits) : 32'(v);
  endfunction

  function automatic bit [31:0] reg_read(input int unsigned r, input bit we, input int unsigned wr, input bit [31:0] wd);
    if (r == 0) return 0;
    if (we && wr == r) return wd;
    return m_regs[r];
  endfunction

  function automatic int unsigned alu_of(input int unsigned f3);
    case (f3)
      2: return 5;
      6: return 3;
      7: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic ex_t decode(input bit [31:0] ins);
    ex_t e;
    int unsigned op, f3;
    e = '{default: 0};
    op = ins[6:0];
    f3 = ins[14:12];
    e.ctl_ok = 1;
    e.imm_ok = 1;
    case (op)
      'h03: begin e.rw = 1; e.alusrc = 1; e.rsrc = 1; e.imm = sext(ins[31:20], 12); end
      'h23: begin e.mw = 1; e.alusrc = 1; e.imm = sext(ins[31:25] * 32 + ins[11:7], 12); end
      'h33: begin e.rw = 1; e.alu = (f3 == 0) ? (ins[30] ? 1 : 0) : alu_of(f3); e.imm_ok = 0; end
      'h13: begin e.rw = 1; e.alusrc = 1; e.alu = alu_of(f3); e.imm = sext(ins[31:20], 12); end
      'h63: begin
        e.br = 1; e.alu = 1;
        e.imm = sext(ins[31] * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2, 13);
      end
      'h6F: begin
        e.jp = 1; e.rw = 1; e.rsrc = 2;
        e.imm = sext(ins[31] * (1 << 20) + ins[19:12] * 4096 + ins[20] * 2048 + ins[30:21] * 2, 21);
      end
      default: begin e.ctl_ok = 0; e.imm_ok = 0; end
    endcase
    return e;
  endfunction

  task automatic step(input bit [31:0] ins, input bit vd, input bit [31:0] pc, input bit we,
                      input bit [4:0] wr, input bit [31:0] wd, input bit fl, input bit hd, input bit rs);
    ex_t nxt, zero;
    bit  lu;
    InstrD = ins; ValidD = vd; PCD = pc; PCPlus4D = pc + 4;
    RegWriteW = we; RDW = wr; ResultW = wd; FlushE = fl; HoldE = hd; rst = rs;
    zero = '{default: 0};
    lu = vd && m_ex.valid && m_ex.rw && m_ex.rsrc == 1 && m_ex.rd != 0 &&
         (m_ex.rd == ins[19:15] || m_ex.rd == ins[24:20]);
    last_stall = lu || hd;
    if (known) stall_q.push_back(last_stall);
    if (rs || fl || (!hd && lu)) nxt = zero;
    else if (hd) nxt = m_ex;
    else begin
      nxt = decode(ins);
      if (!vd) nxt = zero;
      nxt.valid = vd;
      nxt.a = reg_read(ins[19:15], we, wr, wd);
      nxt.b = reg_read(ins[24:20], we, wr, wd);
      nxt.rd = ins[11:7]; nxt.rs1 = ins[19:15]; nxt.rs2 = ins[24:20];
      nxt.pc = pc; nxt.pc4 = pc + 4;
    end
    if (rs) m_regs = '{default: 0};
    else if (we && wr != 0) m_regs[wr] = wd;
    m_ex = nxt;
    exp_q.push_back(nxt);
    if (rs) known = 1;
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (stall_q.size() > 0) chk("StallD", 32'(StallD), 32'(stall_q.pop_front()));
  end

  always @(posedge clk) begin
    ex_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ValidE", 32'(ValidE), 32'(e.valid));
      chk("RegWriteE", 32'(RegWriteE), 32'(e.rw));
      chk("MemWriteE", 32'(MemWriteE), 32'(e.mw));
      chk("BranchE", 32'(BranchE), 32'(e.br));
      chk("JumpE", 32'(JumpE), 32'(e.jp));
      if (e.valid) begin
        chk("RD1_E", RD1_E, e.a);
        chk("RD2_E", RD2_E, e.b);
        chk("RD_E", 32'(RD_E), e.rd);
        chk("Rs1E", 32'(Rs1E), e.rs1);
        chk("Rs2E", 32'(Rs2E), e.rs2);
        chk("PCE", PCE, e.pc);
        chk("PCPlus4E", PCPlus4E, e.pc4);
        if (e.ctl_ok) begin
          chk("ALUSrcE", 32'(ALUSrcE), 32'(e.alusrc));
          chk("ResultSrcE", 32'(ResultSrcE), e.rsrc);
          chk("ALUControlE", 32'(ALUControlE), e.alu);
        end
        if (e.imm_ok) chk("Imm_Ext_E", Imm_Ext_E, e.imm);
      end
    end
  end

  function automatic bit [31:0] rand_instr();
    bit [31:0] r;
    bit [4:0]  rd, s1, s2;
    bit [2:0]  f3;
    bit [2:0]  pick;
    r  = $urandom;
    rd = 5'($urandom_range(0, 7));
    s1 = 5'($urandom_range(0, 7));
    s2 = 5'($urandom_range(0, 7));
    pick = 3'($urandom_range(0, 3));
    f3 = (pick == 0) ? 3'd0 : (pick == 1) ? 3'd2 : (pick == 2) ? 3'd6 : 3'd7;
    case ($urandom_range(0, 7))
      0, 1: return {r[31:20], s1, 3'b010, rd, 7'h03};
      2:    return {r[31:25], s2, s1, 3'b010, r[11:7], 7'h23};
      3:    return {(f3 == 0 && r[0]) ? 7'h20 : 7'h00, s2, s1, f3, rd, 7'h33};
      4:    return {r[31:20], s1, f3, rd, 7'h13};
      5:    return {r[31:25], s2, s1, 3'b000, r[11:7], 7'h63};
      6:    return {r[31:12], rd, 7'h6F};
      default: begin
        pick = 3'($urandom_range(0, 4));
        return {r[31:7], (pick == 0) ? 7'h7F : (pick == 1) ? 7'h37 : (pick == 2) ? 7'h17 :
                         (pick == 3) ? 7'h67 : 7'h73};
      end
    endcase
  endfunction

  initial begin
    bit [31:0] ins, pc;
    bit        vd;
    #2;
    step(32'h0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(32'h0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(32'h00500093, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    step(32'h00318233, 1, 32'h104, 1, 3, 32'hDEADBEEF, 0, 0, 0);
    step(32'h00000233, 1, 32'h108, 1, 0, 32'h00001234, 0, 0, 0);
    step(32'h00012283, 1, 32'h10C, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(32'h00128333, 1, 32'h110, 0, 0, 0, 0, 0, 0);
      if (!last_stall) break;
    end
    step(32'h00112223, 1, 32'h114, 0, 0, 0, 1, 1, 0);
    step(32'h00500093, 1, 32'h118, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(32'h00112223, 1, 32'h11C, 0, 0, 0, 0, 1, 0);
    step(32'hFE000CE3, 1, 32'h120, 0, 0, 0, 0, 0, 0);
    step(32'h0000007F, 1, 32'h124, 0, 0, 0, 0, 0, 0);

    ins = rand_instr(); vd = 1; pc = 32'h200;
    for (int n = 0; n < 2000; n++) begin
      if (!last_stall) begin
        ins = rand_instr();
        vd  = ($urandom_range(0, 7) != 0);
        pc  = pc + 4;
      end
      step(ins, vd, pc, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0);
    end
    step(32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
